// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, special constants,
// operand classes and the multiplier front-end helpers.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN     = 32'h7fc0_0000;
  localparam logic [31:0] INF      = 32'h7f80_0000;
  localparam logic [31:0] NEG_INF  = 32'hff80_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {
    FC_ZERO = 2'd0,
    FC_NORM = 2'd1,
    FC_INF  = 2'd2,
    FC_NAN  = 2'd3
  } fclass_e;

  // Everything the rounding step needs; exp is a 10-bit two's complement value.
  typedef struct packed {
    logic                sign;
    logic [EXP_W+1:0]    exp;
    logic [2*MAN_W+1:0]  prod;
    fclass_e             cls;
  } mul_t;

  function automatic fclass_e classify(input logic [31:0] x);
    if (x[30:23] == '0)       return FC_ZERO;
    else if (x[30:23] == '1)  return (x[22:0] == '0) ? FC_INF : FC_NAN;
    else                      return FC_NORM;
  endfunction

  function automatic fclass_e mul_class(input fclass_e ca, input fclass_e cb);
    if (ca == FC_NAN || cb == FC_NAN)                                    return FC_NAN;
    else if ((ca == FC_INF && cb == FC_ZERO) || (ca == FC_ZERO && cb == FC_INF)) return FC_NAN;
    else if (ca == FC_INF || cb == FC_INF)                               return FC_INF;
    else if (ca == FC_ZERO || cb == FC_ZERO)                             return FC_ZERO;
    else                                                                 return FC_NORM;
  endfunction

  function automatic mul_t mul_stage(input logic [31:0] a, input logic [31:0] b);
    mul_t m;
    m.sign = a[31] ^ b[31];
    m.exp  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    m.prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    m.cls  = mul_class(classify(a), classify(b));
    return m;
  endfunction

endpackage

// File: rtl/fmul_round.sv
// Combinational normalise / round-to-nearest-even / exception step that turns
// the raw significand product into the packed single-precision result.
module fmul_round
  import fpu_pkg::*;
(
  input  mul_t        m,
  output logic [31:0] res
);

  logic                shift;
  logic [22:0]         man;
  logic                guard_b, round_b, sticky_b, up;
  logic [23:0]         man_r;
  logic signed [9:0]   e_n, e_r;

  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    res      = POS_ZERO;
    shift    = m.prod[47];
    man      = shift ? m.prod[46:24] : m.prod[45:23];
    guard_b  = shift ? m.prod[23]    : m.prod[22];
    round_b  = shift ? m.prod[22]    : m.prod[21];
    sticky_b = shift ? |m.prod[21:0] : |m.prod[20:0];
    e_n      = $signed(m.exp) + $signed({9'd0, shift});
    up       = guard_b & (round_b | sticky_b | man[0]);
    man_r    = {1'b0, man} + {23'd0, up};
    // A carry out leaves man_r[22:0] at zero, which is already the renormalised mantissa.
    e_r      = e_n + $signed({9'd0, man_r[23]});

    case (m.cls)
      FC_NAN:  res = QNAN;
      FC_INF:  res = m.sign ? NEG_INF : INF;
      FC_ZERO: res = m.sign ? NEG_ZERO : POS_ZERO;
      default: begin
        if (e_r >= 10'sd255)     res = m.sign ? NEG_INF : INF;
        else if (e_r <= 10'sd0)  res = m.sign ? NEG_ZERO : POS_ZERO;
        else                     res = {m.sign, e_r[7:0], man_r[22:0]};
      end
    endcase
  end

endmodule

// File: rtl/fmul_pipe.sv
// Stallable, flushable single-precision multiplier with LATENCY register stages
// and a valid/tag sideband that moves in lockstep with the data.
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  output logic [31:0]      s,
  output logic [TAG_W-1:0] tag_out
);

  mul_t             mul_d;
  logic [31:0]      res_d;
  logic             valid_q [LATENCY];
  logic [TAG_W-1:0] tag_q   [LATENCY];

  assign mul_d = mul_stage(a, b);

  // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else begin
      if (en) begin
        valid_q[0] <= valid_in;
        tag_q[0]   <= tag_in;
        for (int i = 1; i < LATENCY; i++) begin
          valid_q[i] <= valid_q[i-1];
          tag_q[i]   <= tag_q[i-1];
        end
      end
      // Flush overrides the stall and also kills the slot loading this edge.
      if (flush) begin
        for (int i = 0; i < LATENCY; i++) valid_q[i] <= 1'b0;
      end
    end
  end

  assign valid_out = valid_q[LATENCY-1];
  assign tag_out   = tag_q[LATENCY-1];

  if (LATENCY == 1) begin : g_lat1
    logic [31:0] res_q;

    fmul_round u_round (.m(mul_d), .res(res_d));

    always_ff @(posedge clk) begin
      if (!rst_n)   res_q <= POS_ZERO;
      else if (en)  res_q <= res_d;
    end

    assign s = res_q;
  end else begin : g_latn
    mul_t        mul_q;
    logic [31:0] res_q [LATENCY-1];

    fmul_round u_round (.m(mul_q), .res(res_d));

    // NOTE: the data stages are cleared on reset too, so s reads 0 straight after it.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mul_q <= '0;
        for (int i = 0; i < LATENCY-1; i++) res_q[i] <= POS_ZERO;
      end else if (en) begin
        mul_q    <= mul_d;
        res_q[0] <= res_d;
        for (int i = 1; i < LATENCY-1; i++) res_q[i] <= res_q[i-1];
      end
    end

    assign s = res_q[LATENCY-2];
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe: directed vector table on LATENCY=2,
// stall/flush/reset sequences, and a random sweep of LATENCY=1..6 against a model.
module tb_fmul_pipe;

  localparam int TAG_W = 5;
  localparam int NSW   = 1000;

  logic             clk = 1'b0;
  logic             rst_n, en, flush, valid_in;
  logic [31:0]      a, b;
  logic [TAG_W-1:0] tag_in;

  logic             vo_o [1:6];
  logic [31:0]      s_o  [1:6];
  logic [TAG_W-1:0] tg_o [1:6];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;

  vec_t        vecs [20];
  logic [31:0] sw_a [NSW];
  logic [31:0] sw_b [NSW];
  logic [31:0] sw_e [NSW];

  always #5 clk = ~clk;

  for (genvar L = 1; L <= 6; L++) begin : g_dut
    fmul_pipe #(.LATENCY(L), .TAG_W(TAG_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_in(valid_in),
      .a(a), .b(b), .tag_in(tag_in),
      .valid_out(vo_o[L]), .s(s_o[L]), .tag_out(tg_o[L])
    );
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic [TAG_W-1:0] t);
    valid_in = v;
    a        = x;
    b        = y;
    tag_in   = t;
  endtask

  // Full result word {valid, tag, s} of the instance with latency L.
  function automatic logic [63:0] out_of(input int L);
    return {26'd0, vo_o[L], tg_o[L], s_o[L]};
  endfunction

  function automatic logic [63:0] want(input logic [TAG_W-1:0] t, input logic [31:0] r);
    return {26'd0, 1'b1, t, r};
  endfunction

  // Reference: exact integer product, rounded by comparing the discarded remainder to half an ulp.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic              sg;
    bit                xz, yz, xi, yi, xn, yn;
    longint unsigned   ma, mb, p, q, rem, half;
    int                e, sh;
    sg = x[31] ^ y[31];
    xz = (x[30:23] == 8'd0);
    yz = (y[30:23] == 8'd0);
    xi = (x[30:23] == 8'hff) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'hff) && (y[22:0] == 23'd0);
    xn = (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hff) && (y[22:0] != 23'd0);
    if (xn || yn) return 32'h7fc00000;
    if (xi || yi) return (xz || yz) ? 32'h7fc00000 : {sg, 8'hff, 23'd0};
    if (xz || yz) return {sg, 31'd0};
    ma   = 64'h800000 | 64'(x[22:0]);
    mb   = 64'h800000 | 64'(y[22:0]);
    p    = ma * mb;
    e    = int'(x[30:23]) + int'(y[30:23]) - 127;
    sh   = p[47] ? 24 : 23;
    e    = e + (p[47] ? 1 : 0);
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sg, 8'hff, 23'd0};
    if (e <= 0)   return {sg, 31'd0};
    return {sg, 8'(e), q[22:0]};
  endfunction

  initial begin
    vecs[0]  = '{32'h3f800000, 32'h40000000, 5'd3,  32'h40000000};
    vecs[1]  = '{32'h3fc00000, 32'h3fc00000, 5'd4,  32'h40100000};
    vecs[2]  = '{32'h3fc00000, 32'h3fc00000, 5'd5,  32'h40100000};
    vecs[3]  = '{32'h3fc00000, 32'h3fc00000, 5'd6,  32'h40100000};
    vecs[4]  = '{32'h3f800001, 32'h3f800001, 5'd7,  32'h3f800002};
    vecs[5]  = '{32'h3ffff800, 32'h3f800400, 5'd8,  32'h40000000};
    vecs[6]  = '{32'h7f000000, 32'h7f000000, 5'd9,  32'h7f800000};
    vecs[7]  = '{32'h80800000, 32'h00800000, 5'd10, 32'h80000000};
    vecs[8]  = '{32'h7f800000, 32'h00000000, 5'd11, 32'h7fc00000};
    vecs[9]  = '{32'hff800000, 32'h40000000, 5'd12, 32'hff800000};
    vecs[10] = '{32'h7f800001, 32'h3f800000, 5'd13, 32'h7fc00000};
    vecs[11] = '{32'h80000001, 32'h40000000, 5'd14, 32'h80000000};
    vecs[12] = '{32'h00800000, 32'h3f800000, 5'd15, 32'h00800000};
    vecs[13] = '{32'h00800000, 32'h3f000000, 5'd16, 32'h00000000};
    vecs[14] = '{32'h7f000000, 32'h3fffffff, 5'd17, 32'h7f7fffff};
    vecs[15] = '{32'hc0000000, 32'h40400000, 5'd18, 32'hc0c00000};
    vecs[16] = '{32'hff800000, 32'hff800000, 5'd19, 32'h7f800000};
    vecs[17] = '{32'h00000000, 32'hff800000, 5'd20, 32'h7fc00000};
    vecs[18] = '{32'h3f800001, 32'h40400000, 5'd21, 32'h40400002};
    vecs[19] = '{32'h3f800003, 32'h40400000, 5'd22, 32'h40400004};

    rst_n = 1'b0;
    en    = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, '0);
    repeat (2) step();
    check("reset_state", out_of(2), 64'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Back-to-back vector stream; each result is due one edge after its sample edge.
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) drive(1'b1, vecs[k].a, vecs[k].b, vecs[k].tag);
      else        drive(1'b0, 32'd0, 32'd0, '0);
      step();
      if (k == 0) check("pipe_empty_valid", {63'd0, vo_o[2]}, 64'd0);
      else        check($sformatf("vec%0d", k - 1), out_of(2), want(vecs[k-1].tag, vecs[k-1].exp));
    end

    // Stall: three ops, then four en=0 edges with a junk op on the inputs.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b1, 32'h3f800000, 32'h40400000, 5'd1);
    step();
    check("stall_pre_valid", {63'd0, vo_o[2]}, 64'd0);
    drive(1'b1, 32'h40000000, 32'h40000000, 5'd2);
    step();
    check("stall_op0", out_of(2), want(5'd1, 32'h40400000));
    drive(1'b1, 32'h40400000, 32'h40400000, 5'd3);
    step();
    check("stall_op1", out_of(2), want(5'd2, 32'h40800000));
    en = 1'b0;
    drive(1'b1, 32'h3f800000, 32'h3f800000, 5'd31);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("stall_frozen%0d", i), out_of(2), want(5'd2, 32'h40800000));
    end
    en = 1'b1;
    drive(1'b0, 32'd0, 32'd0, '0);
    step();
    check("stall_op2", out_of(2), want(5'd3, 32'h41100000));
    step();
    check("stall_junk_dropped", {63'd0, vo_o[2]}, 64'd0);

    // Flush kills the op in stage 1 and the one loading on the flush edge.
    drive(1'b1, 32'h40a00000, 32'h40000000, 5'd9);
    step();
    check("flush_pre_valid", {63'd0, vo_o[2]}, 64'd0);
    drive(1'b1, 32'h40a00000, 32'h40400000, 5'd10);
    flush = 1'b1;
    step();
    check("flush_edge_valid", {63'd0, vo_o[2]}, 64'd0);
    flush = 1'b0;
    drive(1'b1, 32'h3f000000, 32'h3f000000, 5'd11);
    step();
    check("flush_op1_killed", {63'd0, vo_o[2]}, 64'd0);
    drive(1'b0, 32'd0, 32'd0, '0);
    step();
    check("flush_next_op", out_of(2), want(5'd11, 32'h3e800000));
    drive(1'b1, 32'h40000000, 32'h40000000, 5'd12);
    step();
    check("flush_stall_pre", {63'd0, vo_o[2]}, 64'd0);
    en    = 1'b0;
    flush = 1'b1;
    drive(1'b0, 32'd0, 32'd0, '0);
    step();
    check("flush_stall_edge", {63'd0, vo_o[2]}, 64'd0);
    en    = 1'b1;
    flush = 1'b0;
    step();
    check("flush_beats_stall", {63'd0, vo_o[2]}, 64'd0);

    // Reset mid-operation, with en=0, clears every instance's outputs.
    drive(1'b1, 32'h40000000, 32'h40400000, 5'd13);
    step();
    drive(1'b1, 32'h3f800000, 32'hc0000000, 5'd14);
    step();
    check("rst_pre_op", out_of(2), want(5'd13, 32'h40c00000));
    rst_n = 1'b0;
    en    = 1'b0;
    step();
    for (int L = 1; L <= 6; L++) check($sformatf("rst_clear_L%0d", L), out_of(L), 64'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    drive(1'b0, 32'd0, 32'd0, '0);
    step();
    check("rst_inflight_lost", {63'd0, vo_o[2]}, 64'd0);

    // Random sweep over all latencies; half the operands get mid-range exponents.
    for (int k = 0; k < NSW; k++) begin
      sw_a[k] = $urandom;
      sw_b[k] = $urandom;
      if ($urandom_range(1, 0) == 1) sw_a[k][30:23] = 8'($urandom_range(154, 100));
      if ($urandom_range(1, 0) == 1) sw_b[k][30:23] = 8'($urandom_range(154, 100));
      sw_e[k] = ref_mul(sw_a[k], sw_b[k]);
    end
    for (int k = 0; k < NSW + 5; k++) begin
      if (k < NSW) drive(1'b1, sw_a[k], sw_b[k], 5'(k));
      else         drive(1'b0, 32'd0, 32'd0, '0);
      step();
      for (int L = 1; L <= 6; L++) begin
        int idx;
        idx = k - L + 1;
        if (idx >= 0 && idx < NSW)
          check($sformatf("sweep_L%0d_%0d", L, idx), out_of(L), want(5'(idx), sw_e[idx]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
